// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared channel state type and counter width helper for button_event_fsm
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_PRESSED,
    ST_DEB_RELEASE
  } chan_state_t;

  // Counter width able to hold values up to n (one spare bit above $clog2).
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/button_channel_fsm.sv
// rtl/button_channel_fsm.sv - one button channel: debounce FSM, press/release pulses, long-press held
// Optional auto-repeat of press_pulse while held is enabled by BUTTON_AUTO_REPEAT_EN.
module button_channel_fsm
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
`ifdef BUTTON_AUTO_REPEAT_EN
  parameter int REPEAT_CYCLES   = 250,
`endif
  parameter int HOLD_CYCLES     = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic sync,
  output logic press_pulse,
  output logic release_pulse,
  output logic held
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  chan_state_t       state, state_next;
  logic [DEB_W-1:0]  deb_cnt, deb_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              held_next, press_next, release_next;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt, rep_next;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      deb_cnt       <= deb_next;
      hold_cnt      <= hold_next;
      held          <= held_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  always_ff @(posedge clock) begin
    if (reset) rep_cnt <= '0;
    else       rep_cnt <= rep_next;
  end
`endif

  always_comb begin
    state_next   = state;
    deb_next     = deb_cnt;
    hold_next    = hold_cnt;
    held_next    = held;
    press_next   = 1'b0;
    release_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (sync) begin
          state_next = ST_DEB_PRESS;
          deb_next   = DEB_W'(1);
        end
      end
      ST_DEB_PRESS: begin
        if (!sync) begin
          state_next = ST_IDLE;
          deb_next   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = ST_PRESSED;
          press_next = 1'b1;
          hold_next  = '0;
          deb_next   = '0;
        end else begin
          deb_next = deb_cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!sync) begin
          state_next = ST_DEB_RELEASE;
          deb_next   = DEB_W'(1);
        end else if (hold_cnt != HOLD_LAST) begin
          hold_next = hold_cnt + 1'b1;
        end else begin
          held_next = 1'b1;
        end
      end
      ST_DEB_RELEASE: begin
        // A bounce back to pressed keeps hold progress so long-press is not restarted.
        if (sync) begin
          state_next = ST_PRESSED;
          deb_next   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_next   = ST_IDLE;
          release_next = 1'b1;
          held_next    = 1'b0;
          hold_next    = '0;
          deb_next     = '0;
        end else begin
          deb_next = deb_cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        deb_next   = '0;
        hold_next  = '0;
        held_next  = 1'b0;
      end
    endcase

`ifdef BUTTON_AUTO_REPEAT_EN
    // Repeats never coincide with the accepted release so the pulses stay exclusive.
    rep_next = rep_cnt;
    if (state_next == ST_IDLE) begin
      rep_next = '0;
    end else if (held_next && !held) begin
      press_next = 1'b1;
      rep_next   = '0;
    end else if (held && (state == ST_PRESSED || state == ST_DEB_RELEASE)) begin
      if (rep_cnt == REP_LAST) begin
        press_next = 1'b1;
        rep_next   = '0;
      end else begin
        rep_next = rep_cnt + 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - two-flop synchroniser for a vector of asynchronous levels
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;

  // Deliberately unreset: these only carry metastability-filtered pin levels.
  always_ff @(posedge clock) begin
    stage1 <= data_in;
    stage2 <= stage1;
  end

  assign data_out = stage2;

endmodule

// File: rtl/button_event_fsm.sv
// rtl/button_event_fsm.sv - multi-channel button front end: sync, debounce, press/release pulses, held, last code
// Optional auto-repeat while held is enabled by BUTTON_AUTO_REPEAT_EN.
module button_event_fsm
  import button_event_pkg::*;
#(
  parameter int NUM_BTN         = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_async,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] held,
  output logic [NUM_BTN-1:0] last_code,
  output logic               any_held
);

  if (NUM_BTN < 1 || NUM_BTN > 32 || DEBOUNCE_CYCLES < 2 ||
      HOLD_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_event_fsm: parameter out of range");
  end

  logic [NUM_BTN-1:0] btn_sync;

  synchronizer #(
    .WIDTH(NUM_BTN)
  ) u_sync (
    .clock   (clock),
    .data_in (btn_async),
    .data_out(btn_sync)
  );

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_channel_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef BUTTON_AUTO_REPEAT_EN
      .REPEAT_CYCLES  (REPEAT_CYCLES),
`endif
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .sync         (btn_sync[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .held         (held[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_code <= '0;
      any_held  <= 1'b0;
    end else begin
      if (|press_pulse) last_code <= press_pulse;
      any_held <= |held;
    end
  end

endmodule

// File: tb/tb_button_event_fsm.sv
// tb/tb_button_event_fsm.sv - directed self-checking bench for button_event_fsm
module tb_button_event_fsm;

  localparam int NB = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int EXP_HOLD_PRESSES = 5;
`else
  localparam int EXP_HOLD_PRESSES = 1;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] btn;
  logic [NB-1:0] press_pulse, release_pulse, held, last_code;
  logic          any_held;

  int checks = 0;
  int passes = 0;

  button_event_fsm #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_async    (btn),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .held         (held),
    .last_code    (last_code),
    .any_held     (any_held)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn   = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if ({press_pulse, release_pulse} !== 8'h00) $display("FAIL reset_pulses got %b exp 0", {press_pulse, release_pulse}); else passes++;
    checks++; if (held !== 4'b0000) $display("FAIL reset_held got %b exp 0000", held); else passes++;
    checks++; if (last_code !== 4'b0000) $display("FAIL reset_last_code got %b exp 0000", last_code); else passes++;
    checks++; if (any_held !== 1'b0) $display("FAIL reset_any_held got %b exp 0", any_held); else passes++;
  endtask

  task automatic test_press();
    int first = -1;
    int cnt = 0;
    logic [NB-1:0] vec = '0;
    btn[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (press_pulse != '0) begin
        cnt++;
        if (first < 0) begin first = t; vec = press_pulse; end
      end
    end
    checks++; if (first !== 6) $display("FAIL press_latency got %0d exp 6", first); else passes++;
    checks++; if (cnt !== 1) $display("FAIL press_count got %0d exp 1", cnt); else passes++;
    checks++; if (vec !== 4'b0001) $display("FAIL press_vector got %b exp 0001", vec); else passes++;
    checks++; if (last_code !== 4'b0001) $display("FAIL press_last_code got %b exp 0001", last_code); else passes++;
  endtask

  task automatic test_release();
    int first = -1;
    int cnt = 0;
    int pcnt = 0;
    btn[0] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (release_pulse != '0) begin
        cnt++;
        if (first < 0 && release_pulse == 4'b0001) first = t;
      end
      if (press_pulse != '0) pcnt++;
    end
    checks++; if (first !== 6) $display("FAIL release_latency got %0d exp 6", first); else passes++;
    checks++; if (cnt !== 1) $display("FAIL release_count got %0d exp 1", cnt); else passes++;
    checks++; if (pcnt !== 0) $display("FAIL release_no_press got %0d exp 0", pcnt); else passes++;
  endtask

  task automatic test_glitch();
    int cnt = 0;
    btn[1] = 1'b1;
    tick();
    tick();
    btn[1] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (press_pulse != '0 || release_pulse != '0) cnt++;
    end
    checks++; if (cnt !== 0) $display("FAIL glitch_pulses got %0d exp 0", cnt); else passes++;
    checks++; if (last_code !== 4'b0001) $display("FAIL glitch_last_code got %b exp 0001", last_code); else passes++;
  endtask

  task automatic test_bounce();
    int pcnt = 0;
    int rcnt = 0;
    int hcnt = 0;
    int first = -1;
    btn[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (press_pulse[0]) pcnt++;
    end
    btn[0] = 1'b0;
    repeat (3) begin
      tick();
      if (release_pulse != '0) rcnt++;
    end
    btn[0] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (release_pulse != '0) rcnt++;
      if (press_pulse[0]) pcnt++;
      if (held != '0) hcnt++;
    end
    checks++; if (rcnt !== 0) $display("FAIL bounce_no_release got %0d exp 0", rcnt); else passes++;
    checks++; if (pcnt !== 1) $display("FAIL bounce_press_count got %0d exp 1", pcnt); else passes++;
    checks++; if (hcnt !== 0) $display("FAIL bounce_no_held got %0d exp 0", hcnt); else passes++;
    btn[0] = 1'b0;
    rcnt = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (release_pulse != '0) begin
        rcnt++;
        if (first < 0 && release_pulse == 4'b0001) first = t;
      end
    end
    checks++; if (first !== 6) $display("FAIL bounce_release_latency got %0d exp 6", first); else passes++;
    checks++; if (rcnt !== 1) $display("FAIL bounce_release_count got %0d exp 1", rcnt); else passes++;
  endtask

  task automatic test_hold();
    int held_rise = -1, any_rise = -1, held_fall = -1, any_fall = -1, rel = -1;
    int pcnt = 0;
    btn[2] = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (t == 40) btn[2] = 1'b0;
      if (press_pulse[2]) pcnt++;
      if (held[2] && held_rise < 0) held_rise = t;
      if (any_held && any_rise < 0) any_rise = t;
      if (held_rise >= 0 && !held[2] && held_fall < 0) held_fall = t;
      if (any_rise >= 0 && !any_held && any_fall < 0) any_fall = t;
      if (release_pulse[2] && rel < 0) rel = t;
    end
    checks++; if (held_rise !== 26) $display("FAIL hold_rise got %0d exp 26", held_rise); else passes++;
    checks++; if (any_rise !== 27) $display("FAIL hold_any_rise got %0d exp 27", any_rise); else passes++;
    checks++; if (rel !== 46) $display("FAIL hold_release got %0d exp 46", rel); else passes++;
    checks++; if (held_fall !== 46) $display("FAIL hold_fall got %0d exp 46", held_fall); else passes++;
    checks++; if (any_fall !== 47) $display("FAIL hold_any_fall got %0d exp 47", any_fall); else passes++;
    checks++; if (pcnt !== EXP_HOLD_PRESSES) $display("FAIL hold_press_count got %0d exp %0d", pcnt, EXP_HOLD_PRESSES); else passes++;
    checks++; if (last_code !== 4'b0100) $display("FAIL hold_last_code got %b exp 0100", last_code); else passes++;
  endtask

  task automatic test_simultaneous();
    int first = -1;
    int cnt = 0;
    logic [NB-1:0] vec = '0;
    btn = 4'b1001;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (press_pulse != '0) begin
        cnt++;
        if (first < 0) begin first = t; vec = press_pulse; end
      end
    end
    checks++; if (vec !== 4'b1001) $display("FAIL simul_vector got %b exp 1001", vec); else passes++;
    checks++; if (first !== 6 || cnt !== 1) $display("FAIL simul_timing got tick %0d count %0d exp 6/1", first, cnt); else passes++;
    checks++; if (last_code !== 4'b1001) $display("FAIL simul_last_code got %b exp 1001", last_code); else passes++;
    btn = '0;
    repeat (10) tick();
  endtask

  task automatic test_reset_abort();
    int cnt = 0;
    btn[1] = 1'b1;
    repeat (3) tick();
    reset  = 1'b1;
    btn[1] = 1'b0;
    repeat (2) tick();
    checks++; if ({press_pulse, release_pulse, held, last_code, any_held} !== 17'h0) $display("FAIL abort_outputs got %b exp 0", {press_pulse, release_pulse, held, last_code, any_held}); else passes++;
    reset = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (press_pulse != '0 || release_pulse != '0) cnt++;
    end
    checks++; if (cnt !== 0) $display("FAIL abort_no_pulse got %0d exp 0", cnt); else passes++;
  endtask

  task automatic test_reset_held();
    int first = -1;
    btn[1] = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (last_code !== 4'b0000) $display("FAIL held_reset_last_code got %b exp 0000", last_code); else passes++;
    reset = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (press_pulse == 4'b0010 && first < 0) first = t;
    end
    checks++; if (first !== 4) $display("FAIL held_reset_press got %0d exp 4", first); else passes++;
    btn[1] = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_bounce();
    test_hold();
    test_simultaneous();
    test_reset_abort();
    test_reset_held();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
